// File: rtl/cpu_mult_pkg.sv
// Shared op encoding, width defaults and signed high-word correction for cpu_mult_pipe.
// High-word ops are built only when CPU_MULT_HIGH_EN is defined.
package cpu_mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXSS = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXUU = 2'd3
  } mult_op_e;

  localparam int DATA_W_DEF = 32;
  // Widest DATA_W the correction helper supports; callers truncate to DATA_W.
  localparam int DATA_W_MAX = 64;

  typedef logic [DATA_W_MAX-1:0] word_max_t;

  // Turns the unsigned high word into the signed/mixed one; the caller keeps only
  // the low DATA_W bits, so the wider arithmetic is still modulo 2^DATA_W.
  function automatic word_max_t high_correct(
    input mult_op_e  op,
    input word_max_t hu,
    input word_max_t a,
    input word_max_t b,
    input logic      sa,
    input logic      sb
  );
    word_max_t h;
    h = hu;
    if (sa && (op == OP_MULXSS || op == OP_MULXSU)) begin
      h = h - b;
    end else begin
      h = h;
    end
    if (sb && (op == OP_MULXSS)) begin
      h = h - a;
    end else begin
      h = h;
    end
    return h;
  endfunction

endpackage

// File: rtl/cpu_mult_pp_cell.sv
// One registered unsigned HALF_W x HALF_W partial-product multiplier
// with load enable and synchronous clear.
module cpu_mult_pp_cell
  import cpu_mult_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic [HALF_W-1:0]   a,
  input  logic [HALF_W-1:0]   b,
  output logic [2*HALF_W-1:0] p_q
);

  logic [2*HALF_W-1:0] p_d;

  // Next product: load on enable, otherwise hold.
  always_comb begin
    if (en) begin
      p_d = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
    end else begin
      p_d = p_q;
    end
  end

  // Product register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/cpu_mult_pipe.sv
// Pipelined M-stage integer multiplier with valid/ready handshake.
// Define CPU_MULT_HIGH_EN to build the high-word ops (MULXSS/MULXSU/MULXUU).
module cpu_mult_pipe
  import cpu_mult_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err
);

  localparam int HALF_W = DATA_W / 2;

  logic adv_s;
  logic accept_s;
  logic clr_s;

  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;
  assign accept_s = in_valid & adv_s;
  assign clr_s    = ~reset_n;

  // ---------------- stage 1: partial products ----------------
  logic [DATA_W-1:0] ll_q, lh_q, hl_q;

  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_ll (
    .clk(clk), .clr(clr_s), .en(adv_s),
    .a(in_src1[HALF_W-1:0]), .b(in_src2[HALF_W-1:0]), .p_q(ll_q)
  );
  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_lh (
    .clk(clk), .clr(clr_s), .en(adv_s),
    .a(in_src1[HALF_W-1:0]), .b(in_src2[DATA_W-1:HALF_W]), .p_q(lh_q)
  );
  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_hl (
    .clk(clk), .clr(clr_s), .en(adv_s),
    .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[HALF_W-1:0]), .p_q(hl_q)
  );

`ifdef CPU_MULT_HIGH_EN
  logic [DATA_W-1:0] hh_q;

  cpu_mult_pp_cell #(.HALF_W(HALF_W)) u_pp_hh (
    .clk(clk), .clr(clr_s), .en(adv_s),
    .a(in_src1[DATA_W-1:HALF_W]), .b(in_src2[DATA_W-1:HALF_W]), .p_q(hh_q)
  );
`endif

  // ---------------- stage 1: control and operand side-band ----------------
  logic     v1_d, v1_q;
  mult_op_e op_d, op_q;
`ifdef CPU_MULT_HIGH_EN
  logic              sa_d, sa_q, sb_d, sb_q;
  logic [DATA_W-1:0] src1_d, src1_q, src2_d, src2_q;
`endif

  // Stage-1 next state: shift on advance, otherwise hold.
  always_comb begin
    if (adv_s) begin
      v1_d   = accept_s;
      op_d   = mult_op_e'(in_op);
`ifdef CPU_MULT_HIGH_EN
      sa_d   = in_src1[DATA_W-1];
      sb_d   = in_src2[DATA_W-1];
      src1_d = in_src1;
      src2_d = in_src2;
`endif
    end else begin
      v1_d   = v1_q;
      op_d   = op_q;
`ifdef CPU_MULT_HIGH_EN
      sa_d   = sa_q;
      sb_d   = sb_q;
      src1_d = src1_q;
      src2_d = src2_q;
`endif
    end
  end

  // Stage-1 registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q   <= 1'b0;
      op_q   <= OP_MUL;
`ifdef CPU_MULT_HIGH_EN
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      src1_q <= '0;
      src2_q <= '0;
`endif
    end else begin
      v1_q   <= v1_d;
      op_q   <= op_d;
`ifdef CPU_MULT_HIGH_EN
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
`endif
    end
  end

  // ---------------- stage 2: combine and select ----------------
  logic [DATA_W-1:0] lo_s;
`ifdef CPU_MULT_HIGH_EN
  logic [2*DATA_W-1:0] mid_s, p_s;
  logic [DATA_W-1:0]   hu_s;

  // Full 2*DATA_W product from the four partial products.
  always_comb begin
    mid_s = {{DATA_W{1'b0}}, lh_q} + {{DATA_W{1'b0}}, hl_q};
    p_s   = {{DATA_W{1'b0}}, ll_q} + (mid_s << HALF_W) + {hh_q, {DATA_W{1'b0}}};
  end

  assign lo_s = p_s[DATA_W-1:0];
  assign hu_s = p_s[2*DATA_W-1:DATA_W];
`else
  // Only the low word is needed; carries out of it are dropped on purpose.
  assign lo_s = ll_q + ((lh_q + hl_q) << HALF_W);
`endif

  logic [DATA_W-1:0] res_s;
  logic              err_s;

  // Result word and unsupported-op flag for the op held in stage 1.
  always_comb begin
    res_s = '0;
    err_s = 1'b0;
    case (op_q)
      OP_MUL: begin
        res_s = lo_s;
        err_s = 1'b0;
      end
      OP_MULXSS, OP_MULXSU, OP_MULXUU: begin
`ifdef CPU_MULT_HIGH_EN
        res_s = DATA_W'(high_correct(op_q, word_max_t'(hu_s), word_max_t'(src1_q),
                                     word_max_t'(src2_q), sa_q, sb_q));
        err_s = 1'b0;
`else
        res_s = '0;
        err_s = 1'b1;
`endif
      end
      default: begin
        res_s = '0;
        err_s = 1'b0;
      end
    endcase
  end

  // ---------------- output stage ----------------
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              v2_d, v2_q;
      logic [DATA_W-1:0] res_d, res_q;
      logic              err_d, err_q;

      // Result register next state: shift on advance, otherwise hold.
      always_comb begin
        if (adv_s) begin
          v2_d  = v1_q;
          res_d = res_s;
          err_d = err_s;
        end else begin
          v2_d  = v2_q;
          res_d = res_q;
          err_d = err_q;
        end
      end

      // Result registers with synchronous active-low reset.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          v2_q  <= 1'b0;
          res_q <= '0;
          err_q <= 1'b0;
        end else begin
          v2_q  <= v2_d;
          res_q <= res_d;
          err_q <= err_d;
        end
      end

      assign out_valid  = v2_q;
      assign out_result = res_q;
      assign out_err    = err_q;
    end else begin : g_out_comb
      assign out_valid  = v1_q;
      assign out_result = res_s;
      assign out_err    = err_s;
    end
  endgenerate

endmodule
